// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, frame 11-bit packets, check start/parity/stop/timeout, buffer good bytes.
// Raw falling edge to fall strobe is SYNC_STAGES+1 cycles; push lands one cycle later. No backpressure: bytes arriving while full are dropped.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  input  logic                              rd_en,
  output logic [7:0]                        rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int TW = $clog2(TIMEOUT_CYC+1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall_q;
  logic                   bit_q;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic stop_fall;
  logic frame_good;
  logic push;
  logic pop;
  logic timeout;

  // Sync flops reset high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      fall_q   <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      bit_q    <= dat_sync[SYNC_STAGES-1];
    end
  end

  assign stop_fall  = fall_q && (state == S_STOP);
  assign frame_good = bit_q && ((^shreg) ^ par_bit);
  assign pop        = rd_en && !empty;
  assign push       = stop_fall && frame_good && (!full || pop);
  assign timeout    = (state != S_IDLE) && !fall_q && (to_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      if (timeout) begin
        state     <= S_IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (fall_q) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!bit_q) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shreg[bit_cnt] <= bit_q;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= bit_q;
            state   <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            // Stop-bit failure outranks parity failure.
            if (!bit_q)                      frame_err  <= 1'b1;
            else if (!((^shreg) ^ par_bit))  parity_err <= 1'b1;
            else if (full && !pop)           overflow   <= 1'b1;
          end
        endcase
      end else if (state == S_IDLE) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign rd_data = empty ? 8'd0 : mem[rd_ptr];

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver for the big_core keyboard path. It synchronises the raw PS/2 clock and data lines and frames 11-bit packets (start, 8 data LSB-first, odd parity, stop). It checks start, parity and stop bits, plus an inter-edge timeout. Good bytes are buffered in a first-word-fall-through FIFO read by the core-side logic.

Parameters:
FIFO_DEPTH, 8, number of byte entries; power of 2, minimum 2.
SYNC_STAGES, 2, flop stages on ps2_clk and ps2_data; minimum 2.
TIMEOUT_CYC, 5000, clk cycles allowed between PS/2 falling edges inside a frame before abort.

Ports:
clk  input  1  system clock; everything is clocked on the rising edge.
rst  input  1  asynchronous, active-low reset.
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk, idle high.
ps2_data  input  1  raw PS/2 data, asynchronous to clk, idle high.
rd_en  input  1  pop the head entry; ignored when empty.
rd_data  output  8  head entry of the FIFO; valid when empty=0.
empty  output  1  FIFO holds no bytes.
full  output  1  FIFO holds FIFO_DEPTH bytes.
count  output  $clog2(FIFO_DEPTH+1)  number of bytes held.
parity_err  output  1  one-cycle pulse: frame dropped, parity not odd.
frame_err  output  1  one-cycle pulse: frame dropped, stop bit 0 or timeout.
overflow  output  1  one-cycle pulse: good byte dropped, FIFO full.

Behaviour:
- Reset (rst=0, async):
  - Synchroniser flops reset to 1, so no spurious edge follows reset.
  - FSM goes to IDLE; bit counter, shift register, timeout counter and FIFO pointers clear.
  - Outputs: rd_data=0, empty=1, full=0, count=0, all error pulses 0.
  - Reset mid-frame discards the partial frame; nothing is pushed.
- Edge detect:
  - fall=1 for one clk when the last sync stage goes 1 to 0 relative to its registered copy.
  - On fall, the bit is sampled from the synchronised data line.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with data=0 goes to DATA, bit_cnt=0. fall with data=1 is ignored and stays in IDLE.
  - DATA: each fall writes shreg[bit_cnt]=data and increments bit_cnt. The fall that stores bit 7 goes to PARITY.
  - PARITY: fall captures the parity bit and goes to STOP.
  - STOP: fall always returns to IDLE, with exactly one outcome:
    - stop=1 and XOR(data,parity)=1, FIFO not full: push the byte.
    - stop=1, parity good, FIFO full: drop the byte, pulse overflow.
    - stop=1, parity bad: pulse parity_err, no push.
    - stop=0: pulse frame_err, no push (frame_err wins over parity_err).
  - Error pulses are asserted in the cycle after the STOP fall.
- Timeout:
  - The counter runs in DATA, PARITY and STOP, and clears on every fall and in IDLE.
  - When the count reaches TIMEOUT_CYC: abort to IDLE, pulse frame_err, no push.
- FIFO (FWFT):
  - A push on the STOP fall edge gives empty=0 and rd_data=byte in the next cycle.
  - rd_en=1 and !empty: the head advances on that edge, and the next entry appears the following cycle.
  - Simultaneous push and pop while full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop otherwise: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. count saturates only by construction.
  - full=(count==FIFO_DEPTH), empty=(count==0), both registered-consistent with count.
- Latency: raw ps2_clk falling edge to fall strobe is SYNC_STAGES+1 clk cycles.

Test Plan:
- Single frame 0x1C (bits start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> empty drops 1 cycle after STOP fall, rd_data=0x1C, count=1; rd_en 1 cycle -> empty=1, count=0.
- Frame 0x1C with parity 1 -> parity_err pulses exactly 1 cycle, count stays 0. Frame 0x1C with stop 0 -> frame_err pulse, count stays 0.
- FIFO_DEPTH=4, frames 0x01,0x02,0x03,0x04,0x05 with no reads -> full=1 after the 4th, overflow pulse on the 5th, count=4; four reads return 0x01..0x04, then empty=1.
- Full FIFO, rd_en held in the cycle the 5th byte pushes -> no overflow, count=4, read order 0x02,0x03,0x04,0x05.
- Start bit plus 3 data bits, then ps2_clk held high for TIMEOUT_CYC+10 cycles -> frame_err pulse, FSM in IDLE; next frame 0xF0 (parity 1) is received as 0xF0.
- Assert rst after 5 data bits of a frame, then release -> outputs at reset values, no spurious fall; next frame 0x5A (parity 1) is received correctly.
